// File: rtl/col_bank_access_sched_if.sv
// Request/bank handshake bundle for the column-bank access scheduler.
// master = requestor/bank side, slave = scheduler.
interface col_bank_access_sched_if #(
    parameter int K   = 4,
    parameter int AW  = 3,
    parameter int IDW = 2
);
    logic              start;
    logic [K-1:0]      rqst_valid;
    logic [K*AW-1:0]   rqst_addr;
    logic              bank_rdy;
    logic              bank_rd_en;
    logic [AW-1:0]     bank_addr;
    logic [IDW-1:0]    bank_tag;
    logic [K-1:0]      grant;
    logic              busy;
    logic              round_done;
    logic              start_err;

    modport master (
        output start, rqst_valid, rqst_addr, bank_rdy,
        input  bank_rd_en, bank_addr, bank_tag, grant, busy, round_done, start_err
    );

    modport slave (
        input  start, rqst_valid, rqst_addr, bank_rdy,
        output bank_rd_en, bank_addr, bank_tag, grant, busy, round_done, start_err
    );
endinterface

// File: rtl/col_bank_access_sched.sv
// Round-robin column-bank access scheduler: latches K pending reads per round and
// issues them one per cycle under bank_rdy. Optional stall counter: STALL_STATS_EN.
module col_bank_access_sched #(
    parameter int K    = 4,
    parameter int AW   = 3,
    parameter int IDW  = 2,
    parameter int CNTW = 8
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    col_bank_access_sched_if.slave bus
`ifdef STALL_STATS_EN
    ,
    output logic [CNTW-1:0]        stall_cnt
`endif
);
    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                 state_q, state_d;
    logic [K-1:0]           pend_q;
    logic [K-1:0][AW-1:0]   addr_q;
    logic [IDW-1:0]         rr_ptr_q;
    logic [K-1:0]           grant_q;
    logic                   round_done_q;
    logic                   start_err_q;

    logic [IDW-1:0]         sel;
    logic [K-1:0]           sel_oh;
    logic                   found;
    int                     idx;
    logic                   rd_en;
    logic                   accept_start;
    logic                   last_accept;

    // Circular scan from rr_ptr: idle slots are simply skipped.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < K; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= K) idx = idx - K;
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
        sel_oh = K'(1) << sel;
    end

    assign accept_start = bus.start && (state_q == S_IDLE);
    assign last_accept  = rd_en && ((pend_q & ~sel_oh) == '0);

    // FSM state register
    always_ff @(posedge sys_clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept_start && (|bus.rqst_valid)) state_d = S_ISSUE;
            S_ISSUE: if (last_accept) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the bank request is combinational so a ready bank is used every cycle
    always_comb begin
        rd_en         = (state_q == S_ISSUE) && bus.bank_rdy && (|pend_q);
        bus.bank_rd_en = rd_en;
        bus.bank_addr  = rd_en ? addr_q[sel] : '0;
        bus.bank_tag   = rd_en ? sel : '0;
        bus.busy       = (state_q == S_ISSUE);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pend_q       <= '0;
            addr_q       <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            round_done_q <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            if (accept_start) begin
                pend_q <= bus.rqst_valid;
                addr_q <= bus.rqst_addr;
            end else if (rd_en) begin
                pend_q <= pend_q & ~sel_oh;
            end
            // Explicit wrap keeps rotation correct when K is not a power of two.
            if (last_accept)
                rr_ptr_q <= (rr_ptr_q == IDW'(K - 1)) ? '0 : rr_ptr_q + 1'b1;
            grant_q      <= rd_en ? sel_oh : '0;
            round_done_q <= last_accept || (accept_start && !(|bus.rqst_valid));
            start_err_q  <= start_err_q || (bus.start && (state_q == S_ISSUE));
        end
    end

    assign bus.grant      = grant_q;
    assign bus.round_done = round_done_q;
    assign bus.start_err  = start_err_q;

`ifdef STALL_STATS_EN
    always_ff @(posedge sys_clk) begin
        if (rst)
            stall_cnt <= '0;
        else if ((state_q == S_ISSUE) && (|pend_q) && !bus.bank_rdy && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_col_bank_access_sched.sv
// Self-checking bench for col_bank_access_sched: directed scenarios plus random
// traffic against a queue-based round-robin reference model.
module tb_col_bank_access_sched;
    localparam int K    = 4;
    localparam int AW   = 3;
    localparam int IDW  = 2;
    localparam int CNTW = 8;

    logic sys_clk;
    logic rst;
    col_bank_access_sched_if #(.K(K), .AW(AW), .IDW(IDW)) bif ();
`ifdef STALL_STATS_EN
    logic [CNTW-1:0] stall_cnt;
`endif

    col_bank_access_sched #(.K(K), .AW(AW), .IDW(IDW), .CNTW(CNTW)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bif.slave)
`ifdef STALL_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the remaining issue order of the current round as a queue
    int             m_q[$];
    int             m_rr;
    bit             m_busy;
    bit             m_err;
    int             m_stall;
    logic [AW-1:0]  m_addr[K];
    logic [K-1:0]   exp_grant;
    bit             exp_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rr = 0; m_busy = 0; m_err = 0; m_stall = 0;
        exp_grant = '0; exp_done = 0;
        for (int j = 0; j < K; j++) m_addr[j] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bif.start = 1'b0; bif.rqst_valid = '0; bif.rqst_addr = '0; bif.bank_rdy = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // One clock: drive inputs, check at negedge, advance model across the edge.
    task automatic cyc(input bit st, input logic [K-1:0] v, input logic [K*AW-1:0] a, input bit rdy);
        bit             was_busy;
        bit             exp_en;
        int             tag;
        logic [K-1:0]   ng;
        bit             nd;
        bif.start = st; bif.rqst_valid = v; bif.rqst_addr = a; bif.bank_rdy = rdy;
        @(negedge sys_clk);
        exp_en = m_busy && rdy && (m_q.size() > 0);
        tag    = exp_en ? m_q[0] : 0;
        chk("bank_rd_en", {31'd0, bif.bank_rd_en}, {31'd0, exp_en});
        chk("bank_tag",   32'(bif.bank_tag),  exp_en ? 32'(tag) : 32'd0);
        chk("bank_addr",  32'(bif.bank_addr), exp_en ? 32'(m_addr[tag]) : 32'd0);
        chk("grant",      32'(bif.grant),     32'(exp_grant));
        chk("round_done", {31'd0, bif.round_done}, {31'd0, exp_done});
        chk("busy",       {31'd0, bif.busy},       {31'd0, m_busy});
        chk("start_err",  {31'd0, bif.start_err},  {31'd0, m_err});
`ifdef STALL_STATS_EN
        chk("stall_cnt",  32'(stall_cnt), 32'(m_stall));
`endif
        was_busy = m_busy;
        ng = '0; nd = 0;
        if (was_busy) begin
            if (exp_en) begin
                void'(m_q.pop_front());
                ng[tag] = 1'b1;
                if (m_q.size() == 0) begin
                    m_busy = 0; nd = 1; m_rr = (m_rr + 1) % K;
                end
            end else if (m_stall < (1 << CNTW) - 1) begin
                m_stall++;
            end
        end
        if (st) begin
            if (was_busy) m_err = 1;
            else begin
                for (int j = 0; j < K; j++) m_addr[j] = a[j*AW +: AW];
                for (int i = 0; i < K; i++)
                    if (v[(m_rr + i) % K]) m_q.push_back((m_rr + i) % K);
                if (m_q.size() == 0) nd = 1;
                else m_busy = 1;
            end
        end
        exp_grant = ng; exp_done = nd;
        @(posedge sys_clk);
        #1;
    endtask

    // Start a round and run it to its final acceptance; inputs wiggle to prove they are ignored.
    task automatic round(input logic [K-1:0] v, input logic [K*AW-1:0] a, input bit rand_rdy);
        int n;
        cyc(1'b1, v, a, 1'b1);
        n = 0;
        while (m_busy && n < 100) begin
            cyc(1'b0, K'($urandom), (K*AW)'($urandom), rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
            n++;
        end
        chk("round_timeout", {31'd0, m_busy}, 32'd0);
    endtask

    initial begin
        model_reset();
        do_reset();
        repeat (2) cyc(1'b0, '0, '0, 1'b0);

        // Full round: valid=1011, r0=5 r1=2 r3=7
        round(4'b1011, {3'd7, 3'd0, 3'd2, 3'd5}, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);

        // Rotation from a fresh pointer: 0123, 1230, 2301, 3012, then 0 again
        do_reset();
        repeat (5) round(4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);

        // Stall: valid=0110, bank_rdy low three cycles
        do_reset();
        cyc(1'b1, 4'b0110, {3'd0, 3'd6, 3'd3, 3'd0}, 1'b1);
        repeat (3) cyc(1'b0, '0, '0, 1'b0);
        repeat (3) cyc(1'b0, '0, '0, 1'b1);

        // Empty round
        cyc(1'b1, 4'b0000, '1, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);

        // Start while busy is ignored and flagged
        cyc(1'b1, 4'b1111, {3'd1, 3'd2, 3'd3, 3'd4}, 1'b1);
        cyc(1'b1, 4'b0001, {3'd7, 3'd7, 3'd7, 3'd7}, 1'b1);
        while (m_busy) cyc(1'b0, '0, '0, 1'b1);

        // Back-to-back: start lands in the round_done cycle
        round(4'b0101, {3'd5, 3'd5, 3'd5, 3'd5}, 1'b0);
        round(4'b1010, {3'd6, 3'd1, 3'd2, 3'd3}, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);

        // Reset after one grant, then a full round restarts at tag 0
        cyc(1'b1, 4'b1111, {3'd1, 3'd2, 3'd3, 3'd4}, 1'b1);
        cyc(1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0);
        do_reset();
        repeat (2) cyc(1'b0, '0, '0, 1'b0);
        round(4'b1111, {3'd0, 3'd7, 3'd6, 3'd5}, 1'b0);
        cyc(1'b0, '0, '0, 1'b1);

        // Random traffic
        for (int r = 0; r < 300; r++)
            cyc($urandom_range(0, 3) == 0, K'($urandom), (K*AW)'($urandom), $urandom_range(0, 3) != 0);
        repeat (6) round(K'($urandom), (K*AW)'($urandom), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
